// File: rtl/aux_pkg.sv
// Shared definitions for the AUX transaction retry controller.
//   - aux_rx_cmd_e : reply command encoding from the AUX decoder
//   - aux_status_e : final transaction outcome reported with done
//   - aux_state_e  : retry controller FSM states
//   - sat_inc4     : saturating 4-bit increment used by the attempt counter
package aux_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    RX_ACK   = 2'b00,
    RX_NACK  = 2'b01,
    RX_DEFER = 2'b10,
    RX_RSVD  = 2'b11
  } aux_rx_cmd_e;

  typedef enum logic [1:0] {
    ST_ACK          = 2'b00,
    ST_NACK_FAIL    = 2'b01,
    ST_DEFER_FAIL   = 2'b10,
    ST_TIMEOUT_FAIL = 2'b11
  } aux_status_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_TX   = 3'd2,
    S_WAIT_RPLY = 3'd3,
    S_GAP       = 3'd4
  } aux_state_e;

  function automatic logic [CNT_W-1:0] sat_inc4(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/aux_retry_ctrl.sv
// AUX request retry controller.
// Sequences one AUX request through transmit, reply wait, timeout and retry,
// then reports the outcome with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_vld/req_rdy  new transaction request; req_rdy high only when idle
//   abort            cancel the current transaction (ignored when idle)
//   tx_start         pulse: encoder (re)sends the buffered request
//   tx_done          pulse: request transmission finished
//   timer_reset      pulse: clear the external reply timeout timer
//   timer_timeout    pulse: reply timeout expired
//   rx_vld, rx_cmd   decoded reply (ACK/NACK/DEFER/reserved)
//   done, status     completion pulse and outcome (status held until next done)
//   attempt_cnt      attempts issued in current/last transaction, saturating
//   dbg_state        current FSM state
//
// Handshake: a request transfers on a rising edge where req_vld && req_rdy.
// req_rdy is low while the done pulse is out, so a request presented in the
// done cycle is not taken.
module aux_retry_ctrl
  import aux_pkg::*;
#(
  parameter int MAX_RETRY  = 7,
  parameter int DEFER_MAX  = 7,
  parameter int GAP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic             abort,
  output logic             tx_start,
  input  logic             tx_done,
  output logic             timer_reset,
  input  logic             timer_timeout,
  input  logic             rx_vld,
  input  logic [1:0]       rx_cmd,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] attempt_cnt,
  output aux_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] DEFER_LIM = CNT_W'(DEFER_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  aux_state_e       state_q, state_d;
  logic [CNT_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [CNT_W-1:0] defer_cnt_q, defer_cnt_d;
  logic [CNT_W-1:0] attempt_cnt_q, attempt_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             tx_start_q, tx_start_d;
  logic             timer_reset_q, timer_reset_d;
  logic             done_q, done_d;
  logic [1:0]       status_q, status_d;

  // Reply classification; rx_vld outranks a same-cycle timeout.
  logic       retry_ev;
  logic [1:0] retry_fail_st;

  always_comb begin
    retry_ev      = 1'b0;
    retry_fail_st = ST_NACK_FAIL;
    if (rx_vld) begin
      retry_ev = (rx_cmd == RX_NACK) || (rx_cmd == RX_RSVD);
    end else if (timer_timeout) begin
      retry_ev      = 1'b1;
      retry_fail_st = ST_TIMEOUT_FAIL;
    end
  end

  always_comb begin
    state_d       = state_q;
    retry_cnt_d   = retry_cnt_q;
    defer_cnt_d   = defer_cnt_q;
    attempt_cnt_d = attempt_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    tx_start_d    = 1'b0;
    timer_reset_d = 1'b0;
    done_d        = 1'b0;
    status_d      = status_q;

    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      timer_reset_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_vld && req_rdy) begin
            retry_cnt_d   = '0;
            defer_cnt_d   = '0;
            // Cleared and then counted for the first SEND in one step.
            attempt_cnt_d = CNT_W'(1);
            tx_start_d    = 1'b1;
            timer_reset_d = 1'b1;
            state_d       = S_SEND;
          end
        end
        S_SEND: begin
          state_d = S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (tx_done) state_d = S_WAIT_RPLY;
        end
        S_WAIT_RPLY: begin
          if (rx_vld && (rx_cmd == RX_ACK)) begin
            timer_reset_d = 1'b1;
            done_d        = 1'b1;
            status_d      = ST_ACK;
            state_d       = S_IDLE;
          end else if (rx_vld && (rx_cmd == RX_DEFER)) begin
            timer_reset_d = 1'b1;
            if (defer_cnt_q == DEFER_LIM) begin
              done_d   = 1'b1;
              status_d = ST_DEFER_FAIL;
              state_d  = S_IDLE;
            end else begin
              defer_cnt_d = defer_cnt_q + 1'b1;
              gap_cnt_d   = '0;
              state_d     = S_GAP;
            end
          end else if (retry_ev) begin
            timer_reset_d = 1'b1;
            if (retry_cnt_q == RETRY_LIM) begin
              done_d   = 1'b1;
              status_d = retry_fail_st;
              state_d  = S_IDLE;
            end else begin
              retry_cnt_d = retry_cnt_q + 1'b1;
              gap_cnt_d   = '0;
              state_d     = S_GAP;
            end
          end
        end
        S_GAP: begin
          // GAP occupies exactly GAP_CYCLES cycles before SEND.
          if (gap_cnt_q == GAP_LAST) begin
            attempt_cnt_d = sat_inc4(attempt_cnt_q);
            tx_start_d    = 1'b1;
            timer_reset_d = 1'b1;
            state_d       = S_SEND;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      retry_cnt_q   <= '0;
      defer_cnt_q   <= '0;
      attempt_cnt_q <= '0;
      gap_cnt_q     <= '0;
      tx_start_q    <= 1'b0;
      timer_reset_q <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      retry_cnt_q   <= retry_cnt_d;
      defer_cnt_q   <= defer_cnt_d;
      attempt_cnt_q <= attempt_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      tx_start_q    <= tx_start_d;
      timer_reset_q <= timer_reset_d;
      done_q        <= done_d;
      status_q      <= status_d;
    end
  end

  assign req_rdy     = (state_q == S_IDLE) && !done_q;
  assign tx_start    = tx_start_q;
  assign timer_reset = timer_reset_q;
  assign done        = done_q;
  assign status      = status_q;
  assign attempt_cnt = attempt_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/aux_retry_ctrl.md
# aux_retry_ctrl

Sequences one AUX request transaction through transmit, reply wait, timeout and retry, and reports the final outcome. Sits between the AUX request interface and the AUX encoder/decoder. Drives the AUX reply timeout timer's reset and consumes its timeout pulse. Retries on NACK, DEFER or timeout with separate limits.

## Interface
Parameters:
- MAX_RETRY, 7: retries allowed after NACK, timeout or reserved reply; shared count.
- DEFER_MAX, 7: retries allowed after DEFER.
- GAP_CYCLES, 4: idle cycles between a failed attempt and the next tx_start; must be 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req_vld  in  1  new transaction request; accepted only when req_rdy=1
- req_rdy  out  1  high only in IDLE
- abort  in  1  cancel the current transaction
- tx_start  out  1  one-cycle pulse; encoder (re)sends the buffered request
- tx_done  in  1  one-cycle pulse at end of request transmission
- timer_reset  out  1  one-cycle pulse clearing the reply timeout timer
- timer_timeout  in  1  one-cycle pulse from the timeout timer
- rx_vld  in  1  reply command decoded
- rx_cmd  in  2  reply command: 00 ACK, 01 NACK, 10 DEFER, 11 reserved
- done  out  1  one-cycle completion pulse
- status  out  2  00 ACK, 01 NACK_FAIL, 10 DEFER_FAIL, 11 TIMEOUT_FAIL; valid with done, held until next done
- attempt_cnt  out  4  attempts issued in the current or last transaction, saturating at 15

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_RPLY, GAP.
- IDLE, on req_vld:
  - clear retry_cnt, defer_cnt and attempt_cnt;
  - go to SEND.
- SEND, single cycle:
  - tx_start=1 and timer_reset=1;
  - attempt_cnt+1;
  - go to WAIT_TX.
- WAIT_TX:
  - wait for tx_done, then go to WAIT_RPLY;
  - rx_vld and timer_timeout are ignored.
- WAIT_RPLY (tx_done ignored):
  - rx_vld with ACK: timer_reset, done, status=ACK; go to IDLE.
  - rx_vld with DEFER: if defer_cnt==DEFER_MAX, timer_reset, done, status=DEFER_FAIL, go to IDLE. Otherwise timer_reset, defer_cnt+1, go to GAP.
  - rx_vld with NACK or reserved: if retry_cnt==MAX_RETRY, timer_reset, done, status=NACK_FAIL, go to IDLE. Otherwise timer_reset, retry_cnt+1, go to GAP.
  - timer_timeout with no rx_vld: same as NACK, but the fail status is TIMEOUT_FAIL.
- GAP: count GAP_CYCLES cycles, then go to SEND.
- abort, in any non-IDLE state:
  - next state IDLE, timer_reset pulse;
  - no done; status unchanged.
- abort in IDLE is ignored.

## Timing
- All outputs registered except req_rdy, which is decoded from the state register.
- Reset values: state IDLE; tx_start, timer_reset, done = 0; status=00; attempt_cnt=0; all internal counters 0. req_rdy=1 during and after reset.
- req_vld sampled at edge N: tx_start is high in cycle N+1 and req_rdy is low from N+1.
- Reply or timeout sampled at edge M: done or GAP entry is visible in cycle M+1.
- After a failed attempt, the next tx_start appears GAP_CYCLES+1 cycles after the failing event was sampled.
- Maximum attempts: 1 + MAX_RETRY + DEFER_MAX, so attempt_cnt saturation at 15 covers the defaults.
- Simultaneous events, in priority order:
  - abort beats everything;
  - rx_vld beats timer_timeout in the same cycle;
  - req_vld in the same cycle as done is not accepted, because req_rdy is already low in that cycle.
- Reset mid-operation: returns to IDLE immediately with no done pulse. The outstanding timer is cleared by its own reset.

## Structure
- Shared package aux_pkg holds:
  - the rx_cmd encoding (ACK/NACK/DEFER/RSVD);
  - the status encoding;
  - the state enum.
- No sub-module. Counters are inline.
- The timeout timer is instantiated beside this block at the AUX top level, not inside it.

## Test plan
- ACK first try: req_vld, tx_done, rx_vld with 00 -> one tx_start, done with status=00, attempt_cnt=1.
- DEFER then ACK: 3 DEFERs then ACK -> 4 tx_start pulses spaced by GAP, status=00, attempt_cnt=4.
- NACK exhaustion: 8 NACKs -> 8 tx_start pulses, done with status=01, attempt_cnt=8, no 9th tx_start.
- Timeout exhaustion, with no rx_vld and timer_timeout after each tx_done -> 8 attempts, status=11; a timer_reset pulse accompanies every tx_start.
- Same-cycle rx_vld(ACK) and timer_timeout -> status=00, no retry. An abort during GAP -> IDLE, no done, no further tx_start, req_rdy=1 next cycle.
- rst_n asserted in WAIT_RPLY -> all outputs return to reset values asynchronously. A new req_vld after release runs normally with attempt_cnt=1.
